pipe_stage_skid_reg: RTL and testbench
======================================

Name: pipe_stage_skid_reg

Overview:
- Parametrised successor to the fixed MEM/WB register: a generic pipeline-stage register with valid/ready handshake, a 2-entry skid buffer, synchronous flush and a saturating stall counter.
- Placed between any two processor stages (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Full throughput, 1-cycle latency.
- Write-enable-style control bits are killed on flush or bubble, so no spurious RegWrite or MemWrite reaches the next stage.

Parameters:
- DATA_W, 96: payload width (e.g. alu_data + mem data + rd, 3x32).
- CTRL_W, 8: control-bit width (RegWrite, MemtoReg, MemWrite, ...).
- KILL_MASK, 8'h0F: ctrl bits forced to 0 on flush, reset and whenever out_valid=0.
- ADDR_W, 5: destination register address width.
- CNT_W, 16: stall counter width.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- flush  in  1  synchronous kill of all held entries.
- in_valid  in  1  upstream entry valid.
- in_ready  out  1  stage can accept (state != SKID).
- in_data  in  DATA_W  upstream payload.
- in_ctrl  in  CTRL_W  upstream control bits.
- in_addr  in  ADDR_W  upstream destination register address.
- out_valid  out  1  output entry valid.
- out_ready  in  1  downstream accepts.
- out_data  out  DATA_W  registered payload.
- out_ctrl  out  CTRL_W  registered control, kill-masked bits gated.
- out_addr  out  ADDR_W  registered destination address.
- stall_cnt  out  CNT_W  saturating count of back-pressure cycles.
- stall_clr  in  1  synchronous clear of stall_cnt.

Behaviour:
- Reset (async, immediate):
  - state=EMPTY, out_valid=0, in_ready=1.
  - out_data, out_ctrl and out_addr = 0.
  - Skid registers = 0, stall_cnt = 0.
- Definitions: in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
- State register encoding: EMPTY (0 held), FULL (main only), SKID (main + skid).
- Outputs are decoded from state/regs only: in_ready = (state!=SKID); out_valid = (state!=EMPTY). No combinational path from in_* to out_*, and none from out_ready to in_ready.
- Transitions, with flush=0:
  - EMPTY: in_fire -> FULL, main<=in.
  - FULL: in_fire & out_fire -> FULL, main<=in.
  - FULL: in_fire & !out_ready -> SKID, skid<=in, main held.
  - FULL: !in_fire & out_fire -> EMPTY.
  - FULL: neither -> hold.
  - SKID: out_fire -> FULL, main<=skid. Input is not accepted (in_ready=0).
  - SKID: otherwise hold.
- Flush:
  - flush=1 -> next state EMPTY regardless of other inputs.
  - An in_fire in the same cycle is dropped.
  - Main and skid ctrl bits selected by KILL_MASK are cleared. Data and addr may hold stale values.
- Kill gating:
  - out_ctrl & KILL_MASK == 0 whenever out_valid=0.
  - On transition to EMPTY, the main ctrl kill bits are cleared in the register (registered, not output gating).
- Latency and throughput:
  - An entry accepted in cycle N appears on out_* in cycle N+1 if the stage was EMPTY, or if FULL with out_fire.
  - Sustained 1 entry/cycle while out_ready=1.
- Ordering: strict FIFO. The skid entry is never overtaken.
- stall_cnt:
  - Increments each cycle out_valid & !out_ready.
  - Saturates at 2^CNT_W-1, no wrap.
  - stall_clr has priority over increment; flush does not clear it.
- Width rules: all fields are pass-through; there is no arithmetic except stall_cnt (+1 with saturation compare).
- Reset mid-operation: in-flight entries are discarded and state returns to EMPTY immediately; no output glitch beyond the async clear.

Decomposition:
- Shared package pipe_pkg:
  - State encoding constants ST_EMPTY=2'd0, ST_FULL=2'd1, ST_SKID=2'd2.
  - Default CTRL bit indices (CTRL_REGWRITE=0, CTRL_MEMWRITE=1, CTRL_MEMTOREG=4) and the default KILL_MASK.
- One natural sub-module: sat_counter (parameter W; inputs inc, clr; output cnt), reused by other stages' performance counters.

Test Plan:
- Stream: in_valid=1 with data 1..8, out_ready=1 -> out_data 1..8 on consecutive cycles starting 1 cycle after the first accept; in_ready stays 1; stall_cnt=0.
- Back-pressure: send A=0x11, B=0x22, drop out_ready for 3 cycles -> state SKID, in_ready=0, out_data=0x11 held, stall_cnt=3; release -> 0x11 then 0x22, no loss and no duplication.
- Flush in SKID with in_valid=1, C=0x33, in_ctrl=8'hFF -> next cycle out_valid=0, out_ctrl&8'h0F=0, in_ready=1; C never appears on the output.
- Async reset asserted mid-cycle while FULL -> out_valid=0 and all outputs 0 before the next clk edge; after release, the first accepted entry passes normally.
- stall_cnt with CNT_W=4 and out_ready=0 for 20 cycles -> saturates at 15; stall_clr together with a stall -> 0 next cycle.
- Random in_valid/out_ready (10k cycles) against a reference queue model -> output order matches and no entry is lost or duplicated.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared definitions for the generic pipeline-stage register: occupancy
// encoding, default control-bit positions and the default kill mask.
package pipe_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FULL  = 2'd1,
    ST_SKID  = 2'd2
  } pipe_state_e;

  localparam int CTRL_REGWRITE = 0;
  localparam int CTRL_MEMWRITE = 1;
  localparam int CTRL_MEMTOREG = 4;

  localparam logic [7:0] DEFAULT_KILL_MASK = 8'h0F;

endpackage

// File: rtl/pipe_stage_skid_reg_if.sv
// Upstream/downstream valid-ready handshake bundle of one pipeline stage.
interface pipe_stage_skid_reg_if #(
  parameter int DATA_W = 96,
  parameter int CTRL_W = 8,
  parameter int ADDR_W = 5
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic [CTRL_W-1:0] in_ctrl;
  logic [ADDR_W-1:0] in_addr;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [CTRL_W-1:0] out_ctrl;
  logic [ADDR_W-1:0] out_addr;

  modport master (
    output in_valid, in_data, in_ctrl, in_addr, out_ready,
    input  in_ready, out_valid, out_data, out_ctrl, out_addr
  );

  modport slave (
    input  in_valid, in_data, in_ctrl, in_addr, out_ready,
    output in_ready, out_valid, out_data, out_ctrl, out_addr
  );
endinterface

// File: rtl/sat_counter.sv
// Saturating event counter with synchronous clear (clear wins over increment).
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] cnt
);

  function automatic logic [W-1:0] sat_inc(input logic [W-1:0] v);
    return (v == {W{1'b1}}) ? v : v + 1'b1;
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc) begin
      cnt <= sat_inc(cnt);
    end
  end

endmodule

// File: rtl/pipe_stage_skid_reg.sv
// Pipeline-stage register with a one-deep skid entry, flush, kill-masked
// control bits and a saturating back-pressure counter.
module pipe_stage_skid_reg
  import pipe_pkg::*;
#(
  parameter int                DATA_W    = 96,
  parameter int                CTRL_W    = 8,
  parameter logic [CTRL_W-1:0] KILL_MASK = DEFAULT_KILL_MASK,
  parameter int                ADDR_W    = 5,
  parameter int                CNT_W     = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  stall_clr,
  output logic [CNT_W-1:0]      stall_cnt,
  pipe_stage_skid_reg_if.slave  bus
);

  pipe_state_e       state_q, state_d;
  logic              in_fire, out_fire;
  logic              ld_main_in, ld_main_skid, ld_skid, kill_main;

  logic [DATA_W-1:0] main_data_p1, skid_data_p2;
  logic [CTRL_W-1:0] main_ctrl_p1, skid_ctrl_p2;
  logic [ADDR_W-1:0] main_addr_p1, skid_addr_p2;

  // Handshake outputs depend on the state register only.
  assign bus.in_ready  = (state_q != ST_SKID);
  assign bus.out_valid = (state_q != ST_EMPTY);
  assign in_fire       = bus.in_valid & bus.in_ready;
  assign out_fire      = bus.out_valid & bus.out_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ST_EMPTY;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d      = state_q;
    ld_main_in   = 1'b0;
    ld_main_skid = 1'b0;
    ld_skid      = 1'b0;
    kill_main    = 1'b0;
    if (flush) begin
      state_d   = ST_EMPTY;
      kill_main = 1'b1;
    end else begin
      unique case (state_q)
        ST_EMPTY: if (in_fire) begin
          state_d    = ST_FULL;
          ld_main_in = 1'b1;
        end
        ST_FULL: begin
          if (in_fire && out_fire) begin
            ld_main_in = 1'b1;
          end else if (in_fire) begin
            state_d = ST_SKID;
            ld_skid = 1'b1;
          end else if (out_fire) begin
            state_d   = ST_EMPTY;
            kill_main = 1'b1;
          end
        end
        ST_SKID: if (out_fire) begin
          state_d      = ST_FULL;
          ld_main_skid = 1'b1;
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  // ---- p1: main entry driving the outputs ----
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      main_data_p1 <= '0;
      main_ctrl_p1 <= '0;
      main_addr_p1 <= '0;
    end else if (ld_main_in) begin
      main_data_p1 <= bus.in_data;
      main_ctrl_p1 <= bus.in_ctrl;
      main_addr_p1 <= bus.in_addr;
    end else if (ld_main_skid) begin
      main_data_p1 <= skid_data_p2;
      main_ctrl_p1 <= skid_ctrl_p2;
      main_addr_p1 <= skid_addr_p2;
    end else if (kill_main) begin
      main_ctrl_p1 <= main_ctrl_p1 & ~KILL_MASK;
    end
  end

  // ---- p2: skid entry, filled only while the output is stalled ----
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      skid_data_p2 <= '0;
      skid_ctrl_p2 <= '0;
      skid_addr_p2 <= '0;
    end else if (ld_skid) begin
      skid_data_p2 <= bus.in_data;
      skid_ctrl_p2 <= bus.in_ctrl;
      skid_addr_p2 <= bus.in_addr;
    end else if (flush) begin
      skid_ctrl_p2 <= skid_ctrl_p2 & ~KILL_MASK;
    end
  end

  assign bus.out_data = main_data_p1;
  assign bus.out_addr = main_addr_p1;
  assign bus.out_ctrl = bus.out_valid ? main_ctrl_p1 : (main_ctrl_p1 & ~KILL_MASK);

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (bus.out_valid & ~bus.out_ready),
    .clr   (stall_clr),
    .cnt   (stall_cnt)
  );

endmodule

// File: tb/tb_pipe_stage_skid_reg.sv
// Bench for pipe_stage_skid_reg: directed scenarios plus random traffic,
// all checked against a two-slot FIFO reference model.
module tb_pipe_stage_skid_reg;
  import pipe_pkg::*;

  localparam int         DATA_W = 96;
  localparam int         CTRL_W = 8;
  localparam int         ADDR_W = 5;
  localparam int         CNT_W  = 4;
  localparam logic [7:0] KMASK  = 8'h0F;
  localparam int         CMAX   = (1 << CNT_W) - 1;

  typedef struct packed {
    logic [DATA_W-1:0] d;
    logic [CTRL_W-1:0] c;
    logic [ADDR_W-1:0] a;
  } ent_t;

  logic             clk = 1'b0;
  logic             reset;
  logic             flush;
  logic             stall_clr;
  logic [CNT_W-1:0] stall_cnt;

  pipe_stage_skid_reg_if #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .ADDR_W(ADDR_W)) bus ();

  pipe_stage_skid_reg #(
    .DATA_W(DATA_W), .CTRL_W(CTRL_W), .KILL_MASK(KMASK), .ADDR_W(ADDR_W), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .reset(reset), .flush(flush), .stall_clr(stall_clr),
    .stall_cnt(stall_cnt), .bus(bus)
  );

  always #5 clk = ~clk;

  int   vectors    = 0;
  int   miscompares = 0;
  ent_t mq[$];
  int   m_cnt = 0;

  task automatic check_val(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic ent_t mk(input logic [DATA_W-1:0] d, input logic [CTRL_W-1:0] c,
                              input logic [ADDR_W-1:0] a);
    ent_t e;
    e.d = d; e.c = c; e.a = a;
    return e;
  endfunction

  task automatic compare_all();
    check_val("out_valid", bus.out_valid, mq.size() > 0);
    check_val("in_ready", bus.in_ready, mq.size() < 2);
    if (mq.size() > 0) begin
      check_val("out_data", bus.out_data, mq[0].d);
      check_val("out_ctrl", bus.out_ctrl, mq[0].c);
      check_val("out_addr", bus.out_addr, mq[0].a);
    end else begin
      check_val("ctrl_kill", bus.out_ctrl & KMASK, 0);
    end
    check_val("stall_cnt", stall_cnt, m_cnt);
  endtask

  // Apply one cycle of inputs, advance the FIFO model, then compare.
  task automatic drive(input logic iv, input ent_t e, input logic ordy,
                       input logic fl, input logic clr);
    logic m_in, m_out, m_stall;
    bus.in_valid  = iv;
    bus.in_data   = e.d;
    bus.in_ctrl   = e.c;
    bus.in_addr   = e.a;
    bus.out_ready = ordy;
    flush         = fl;
    stall_clr     = clr;
    m_in    = iv && (mq.size() < 2);
    m_out   = (mq.size() > 0) && ordy;
    m_stall = (mq.size() > 0) && !ordy;
    @(posedge clk);
    #1;
    if (fl) begin
      mq.delete();
    end else begin
      if (m_out) void'(mq.pop_front());
      if (m_in) mq.push_back(e);
    end
    if (clr) m_cnt = 0;
    else if (m_stall && m_cnt < CMAX) m_cnt++;
    compare_all();
  endtask

  task automatic idle(input logic ordy);
    drive(1'b0, mk('0, '0, '0), ordy, 1'b0, 1'b0);
  endtask

  ent_t ea, eb, ec;
  logic [CTRL_W-1:0] wr_ctrl;

  initial begin
    reset = 1'b1; flush = 1'b0; stall_clr = 1'b0;
    bus.in_valid = 1'b0; bus.in_data = '0; bus.in_ctrl = '0; bus.in_addr = '0;
    bus.out_ready = 1'b0;
    #12;
    compare_all();
    check_val("rst_data", bus.out_data, 0);
    reset = 1'b0;

    // Streaming at full rate
    for (int i = 1; i <= 8; i++) begin
      drive(1'b1, mk(DATA_W'(i), 8'h01, ADDR_W'(i)), 1'b1, 1'b0, 1'b0);
      check_val("stream_data", bus.out_data, i);
    end
    idle(1'b1);

    // Back-pressure into the skid slot
    ea = mk(96'h11, 8'h03, 5'd1);
    eb = mk(96'h22, 8'h05, 5'd2);
    drive(1'b1, ea, 1'b1, 1'b0, 1'b0);
    drive(1'b1, eb, 1'b0, 1'b0, 1'b0);
    idle(1'b0);
    idle(1'b0);
    check_val("bp_hold", bus.out_data, 96'h11);
    check_val("bp_ready", bus.in_ready, 1'b0);
    check_val("bp_cnt", stall_cnt, 3);
    idle(1'b1);
    check_val("bp_second", bus.out_data, 96'h22);
    idle(1'b1);

    // Flush while in SKID with a write-enabled entry waiting
    wr_ctrl = '0;
    wr_ctrl[CTRL_REGWRITE] = 1'b1;
    wr_ctrl[CTRL_MEMWRITE] = 1'b1;
    wr_ctrl[CTRL_MEMTOREG] = 1'b1;
    drive(1'b1, mk(96'h11, wr_ctrl, 5'd3), 1'b1, 1'b0, 1'b0);
    drive(1'b1, mk(96'h22, wr_ctrl, 5'd4), 1'b0, 1'b0, 1'b0);
    ec = mk(96'h33, 8'hFF, 5'd5);
    drive(1'b1, ec, 1'b0, 1'b1, 1'b0);
    check_val("fl_valid", bus.out_valid, 1'b0);
    check_val("fl_kill", bus.out_ctrl & KMASK, 0);
    check_val("fl_ready", bus.in_ready, 1'b1);
    idle(1'b1);
    idle(1'b1);

    // Stall counter saturation and clear priority
    drive(1'b1, mk(96'h44, 8'h00, 5'd6), 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 20; i++) idle(1'b0);
    check_val("sat_cnt", stall_cnt, CMAX);
    drive(1'b0, mk('0, '0, '0), 1'b0, 1'b0, 1'b1);
    check_val("clr_cnt", stall_cnt, 0);
    idle(1'b1);

    // Asynchronous reset between clock edges while FULL
    drive(1'b1, mk(96'h55, 8'hFF, 5'd7), 1'b1, 1'b0, 1'b0);
    idle(1'b0);
    #3;
    reset = 1'b1;
    #1;
    mq.delete();
    m_cnt = 0;
    check_val("ar_valid", bus.out_valid, 1'b0);
    check_val("ar_data", bus.out_data, 0);
    check_val("ar_ctrl", bus.out_ctrl, 0);
    check_val("ar_addr", bus.out_addr, 0);
    compare_all();
    #2;
    reset = 1'b0;
    drive(1'b1, mk(96'h66, 8'h0A, 5'd9), 1'b1, 1'b0, 1'b0);
    check_val("ar_after", bus.out_data, 96'h66);

    // Random traffic
    for (int n = 0; n < 10000; n++) begin
      drive(($urandom % 4) != 0,
            mk({$urandom, $urandom, $urandom}, CTRL_W'($urandom), ADDR_W'($urandom)),
            ($urandom % 3) != 0, ($urandom % 32) == 0, ($urandom % 64) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
